// File: rtl/slurmboy_pkg.sv
// SlurmBoy reset sequencer shared types.
// State encoding and counter width helper.
package slurmboy_pkg;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t HOLD     = 2'd0;
  localparam seq_state_t LOCKWAIT = 2'd1;
  localparam seq_state_t RELEASE  = 2'd2;
  localparam seq_state_t RUN      = 2'd3;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/slurmboy_sync2.sv
// SlurmBoy two-flop synchroniser.
// Async active-low reset to RST_VAL.
module slurmboy_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // two metastability stages
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/slurmboy_reset_seq.sv
// SlurmBoy power-on reset sequencer.
// Hold, lock filter, staggered per-domain release.
module slurmboy_reset_seq
  import slurmboy_pkg::*;
#(
  parameter int NUM_DOMAINS    = 3,
  parameter int POR_CYCLES     = 10000,
  parameter int LOCK_FILTER    = 256,
  parameter int STAGGER_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   RSTb,
  input  logic                   pll_locked,
  input  logic                   sw_reset_req,
  output logic [NUM_DOMAINS-1:0] rst_out_n,
  output logic                   all_released,
  output logic [1:0]             seq_state
);

  localparam int POR_W  = cnt_w(POR_CYCLES);
  localparam int LOCK_W = cnt_w(LOCK_FILTER);
  localparam int STG_W  = cnt_w(STAGGER_CYCLES);

  seq_state_t              state_q, state_d;
  logic [POR_W-1:0]        por_q, por_d;
  logic [LOCK_W-1:0]       lock_q, lock_d;
  logic [STG_W-1:0]        stg_q, stg_d;
  logic [NUM_DOMAINS-1:0]  rst_q, rst_d;
  logic                    all_q, all_d;

  logic                    lock_s;
  logic                    por_done;
  logic                    lock_done;
  logic                    stg_done;
  logic                    lock_loss;
  logic [NUM_DOMAINS-1:0]  rst_next;

  slurmboy_sync2 #(
    .RST_VAL(1'b0)
  ) u_lock_sync (
    .clk_i (clk),
    .rst_ni(RSTb),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

  assign por_done  = (por_q == POR_W'(POR_CYCLES - 1));
  assign lock_done = lock_s && (lock_q == LOCK_W'(LOCK_FILTER - 1));
  assign stg_done  = (stg_q == STG_W'(STAGGER_CYCLES - 1));
  assign lock_loss = !lock_s &&
                     ((state_q == RELEASE) || (state_q == RUN));
  // next domain released in index order: shift a one in from bit 0
  assign rst_next  = NUM_DOMAINS'({rst_q, 1'b1});

  // state, counters and registered reset outputs
  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) begin
      state_q <= HOLD;
      por_q   <= '0;
      lock_q  <= '0;
      stg_q   <= '0;
      rst_q   <= '0;
      all_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      por_q   <= por_d;
      lock_q  <= lock_d;
      stg_q   <= stg_d;
      rst_q   <= rst_d;
      all_q   <= all_d;
    end
  end

  // next state and counter updates
  always_comb begin
    state_d = state_q;
    por_d   = por_q;
    lock_d  = lock_q;
    stg_d   = stg_q;
    if (sw_reset_req) begin
      state_d = HOLD;
      por_d   = '0;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (por_done) begin
            state_d = LOCKWAIT;
            por_d   = '0;
            lock_d  = '0;
          end else begin
            por_d = por_q + POR_W'(1);
          end
        end
        LOCKWAIT: begin
          if (!lock_s) begin
            lock_d = '0;
          end else if (lock_done) begin
            state_d = (NUM_DOMAINS == 1) ? RUN : RELEASE;
            lock_d  = '0;
            stg_d   = '0;
          end else begin
            lock_d = lock_q + LOCK_W'(1);
          end
        end
        RELEASE: begin
          if (!lock_s) begin
            state_d = LOCKWAIT;
            lock_d  = '0;
          end else if (stg_done) begin
            stg_d = '0;
            if (rst_next[NUM_DOMAINS-1]) state_d = RUN;
          end else begin
            stg_d = stg_q + STG_W'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_d = LOCKWAIT;
            lock_d  = '0;
          end
        end
      endcase
    end
  end

  // reset outputs: all fall together, rise one index at a time
  always_comb begin
    rst_d = rst_q;
    all_d = all_q;
    if (sw_reset_req || lock_loss) begin
      rst_d = '0;
      all_d = 1'b0;
    end else if (state_q == LOCKWAIT && lock_done) begin
      rst_d = NUM_DOMAINS'(1);
      all_d = (NUM_DOMAINS == 1);
    end else if (state_q == RELEASE && stg_done) begin
      rst_d = rst_next;
      all_d = rst_next[NUM_DOMAINS-1];
    end
  end

  assign rst_out_n    = rst_q;
  assign all_released = all_q;
  assign seq_state    = state_q;

endmodule

// File: tb/tb_slurmboy_reset_seq.sv
// SlurmBoy reset sequencer bench.
// Directed vectors, small config (8/4/3/3).
module tb_slurmboy_reset_seq;

  logic       clk = 1'b0;
  logic       RSTb = 1'b0;
  logic       pll_locked = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic [2:0] rst_out_n;
  logic       all_released;
  logic [1:0] seq_state;

  int n_chk = 0;
  int n_err = 0;

  slurmboy_reset_seq #(
    .NUM_DOMAINS   (3),
    .POR_CYCLES    (8),
    .LOCK_FILTER   (4),
    .STAGGER_CYCLES(3)
  ) dut (
    .clk         (clk),
    .RSTb        (RSTb),
    .pll_locked  (pll_locked),
    .sw_reset_req(sw_reset_req),
    .rst_out_n   (rst_out_n),
    .all_released(all_released),
    .seq_state   (seq_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RSTb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.rst_out_n", 32'(rst_out_n), 32'h0);
    check("rst.all", 32'(all_released), 32'h0);
    check("rst.state", 32'(seq_state), 32'h0);
    @(negedge clk);
    RSTb = 1'b1;
  endtask

  // edges 1..18 with lock stable high
  task automatic run_seq1(input string pfx);
    logic [2:0] er;
    logic [1:0] es;
    for (int e = 1; e <= 18; e++) begin
      step(1);
      er = (e < 12) ? 3'b000 : (e < 15) ? 3'b001 :
           (e < 18) ? 3'b011 : 3'b111;
      es = (e < 8) ? 2'd0 : (e < 12) ? 2'd1 :
           (e < 18) ? 2'd2 : 2'd3;
      check($sformatf("%s.rst@%0d", pfx, e), 32'(rst_out_n), 32'(er));
      check($sformatf("%s.st@%0d", pfx, e), 32'(seq_state), 32'(es));
      check($sformatf("%s.all@%0d", pfx, e), 32'(all_released),
            32'(e >= 18));
    end
  endtask

  initial begin : main
    logic [6:0] pv;

    // 1: lock high throughout
    pll_locked = 1'b1;
    do_reset();
    run_seq1("s1");

    // 3: one-cycle lock drop while in RUN
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(1);
    check("s3.rst@E+1", 32'(rst_out_n), 32'h7);
    step(1);
    check("s3.rst@E+2", 32'(rst_out_n), 32'h0);
    check("s3.st@E+2", 32'(seq_state), 32'h1);
    check("s3.all@E+2", 32'(all_released), 32'h0);
    step(3);
    check("s3.rst@E+5", 32'(rst_out_n), 32'h0);
    step(1);
    check("s3.rst@E+6", 32'(rst_out_n), 32'h1);
    step(3);
    check("s3.rst@E+9", 32'(rst_out_n), 32'h3);
    step(3);
    check("s3.rst@E+12", 32'(rst_out_n), 32'h7);
    check("s3.all@E+12", 32'(all_released), 32'h1);

    // 2: lock low until after edge 20
    pll_locked = 1'b0;
    do_reset();
    step(20);
    check("s2.rst@20", 32'(rst_out_n), 32'h0);
    check("s2.st@20", 32'(seq_state), 32'h1);
    pll_locked = 1'b1;
    step(5);
    check("s2.rst@25", 32'(rst_out_n), 32'h0);
    step(1);
    check("s2.rst@26", 32'(rst_out_n), 32'h1);
    check("s2.st@26", 32'(seq_state), 32'h2);

    // 4: software request mid-release
    pll_locked = 1'b1;
    do_reset();
    step(15);
    check("s4.rst@15", 32'(rst_out_n), 32'h3);
    sw_reset_req = 1'b1;
    step(1);
    sw_reset_req = 1'b0;
    check("s4.rst@R", 32'(rst_out_n), 32'h0);
    check("s4.st@R", 32'(seq_state), 32'h0);
    step(8);
    check("s4.st@R+8", 32'(seq_state), 32'h1);
    step(3);
    check("s4.rst@R+11", 32'(rst_out_n), 32'h0);
    step(1);
    check("s4.rst@R+12", 32'(rst_out_n), 32'h1);

    // 5: filter restart on a single low sample
    pll_locked = 1'b0;
    do_reset();
    step(10);
    check("s5.st@10", 32'(seq_state), 32'h1);
    pv = 7'b1111011;
    for (int i = 0; i < 7; i++) begin
      pll_locked = pv[i];
      step(1);
    end
    pll_locked = 1'b1;
    step(1);
    check("s5.rst@18", 32'(rst_out_n), 32'h0);
    step(1);
    check("s5.rst@19", 32'(rst_out_n), 32'h1);

    // 6: async reset mid-release, then clean rerun
    pll_locked = 1'b1;
    do_reset();
    step(15);
    check("s6.rst@15", 32'(rst_out_n), 32'h3);
    #2 RSTb = 1'b0;
    #1;
    check("s6.async.rst", 32'(rst_out_n), 32'h0);
    check("s6.async.st", 32'(seq_state), 32'h0);
    @(negedge clk);
    RSTb = 1'b1;
    run_seq1("s6");

    // 6b: sw request and lock loss on the same edge
    pll_locked = 1'b0;
    step(2);
    check("s6b.rst@pre", 32'(rst_out_n), 32'h7);
    sw_reset_req = 1'b1;
    step(1);
    sw_reset_req = 1'b0;
    check("s6b.st", 32'(seq_state), 32'h0);
    check("s6b.rst", 32'(rst_out_n), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
